multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle main control decoder: a Moore/Mealy FSM that sequences the CPU datapath through FETCH/DECODE/EXEC/MEM/WB for the supported MIPS subset. It issues per-cycle control strobes instead of one static decode. It also adds a memory ready/wait handshake, a wait-state timeout, sticky fault reporting for illegal opcodes and timeouts, and a retired-instruction counter. It sits between the instruction register and the datapath muxes, ALU, register file and unified memory port.

## Interface
- INSTR_W, 32, instruction width; opcode is always bits [31:26] and func is bits [5:0].
- ALUOP_W, 3, alu_op width, minimum 3; codes are zero-extended.
- TIMEOUT, 16, maximum consecutive wait cycles with mem_ready low before a fault; 0 disables the timeout.
- COUNT_W, 32, width of retire_cnt.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- instru  in  INSTR_W  current instruction-register contents.
- mem_ready  in  1  memory completes the current access this cycle.
- zero  in  1  ALU zero flag, used for beq.
- mem_req  out  1  memory access request.
- mem_we  out  1  write request; only asserted together with mem_req.
- iord  out  1  address source: 0 = PC, 1 = ALU result.
- ir_wr  out  1  load the instruction register.
- pc_wr  out  1  PC write enable.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- alu_src  out  1  ALU B operand: 1 = extended immediate.
- alu_op  out  ALUOP_W  ALU operation: 0 = add, 1 = sub, 2 = or, 4 = R-type (use func).
- ext_op  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- reg_dst  out  1  write register: 1 = rd, 0 = rt.
- r_type  out  1  current instruction is R-type.
- reg_wr  out  1  register-file write.
- mem_to_reg  out  1  write-back data: 1 = memory, 0 = ALU.
- func  out  6  equal to instru[5:0] at all times.
- state  out  3  current state code.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout.
- retire_cnt  out  COUNT_W  number of retired instructions.

## Operation
States and transitions:
- FETCH: mem_req=1, iord=0. When mem_ready=1, assert ir_wr=1 and pc_wr=1 with pc_src=00, then go to DECODE.
- DECODE: latch an instruction class from opcode.
  - 000000 (R), 001101 (ori), 001001 (addiu), 100011 (lw), 101011 (sw), 000100 (beq) go to EXEC.
  - 000010 (j): pc_wr=1, pc_src=10, retire, go to FETCH.
  - Any other opcode: go to FAULT with fault_code=01.
- EXEC: drive the ALU controls for the latched class.
  - R: alu_op=4, alu_src=0. ori: alu_op=2, ext_op=0, alu_src=1. addiu, lw, sw: alu_op=0, ext_op=1, alu_src=1. beq: alu_op=1, alu_src=0.
  - Next state: R, ori, addiu go to WB; lw goes to MEMRD; sw goes to MEMWR.
  - beq: pc_wr=zero, pc_src=01, retire, go to FETCH.
- MEMRD: mem_req=1, iord=1. When mem_ready=1, go to WB.
- MEMWR: mem_req=1, mem_we=1, iord=1. When mem_ready=1, retire and go to FETCH.
- WB: reg_wr=1, reg_dst=1 for R only, mem_to_reg=1 for lw only. Retire and go to FETCH.
- FAULT: all strobes 0, fault=1. The block stays here until reset.

General rules:
- ALU controls (alu_op, alu_src, ext_op, r_type) hold their EXEC values through MEMRD, MEMWR and WB.
- Outputs not listed for a state are 0.
- Wait counter: cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle mem_ready=0 in those states. When TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready still 0, go to FAULT with fault_code=10. A mem_ready=1 on that same cycle wins: the access completes and there is no fault.
- retire_cnt increments by 1 on each retire event and wraps modulo 2^COUNT_W.

## Timing
- Reset: state=FETCH, retire_cnt=0, fault=0, fault_code=00, wait counter=0, latched class=R.
  - All strobes are 0 while rst_n=0.
  - Once reset is released, FETCH strobes appear the same cycle.
- Reset asserted mid-instruction aborts the instruction: no retire, no write strobes on the next edge.
- Strobes are combinational from state, latched class, mem_ready and zero. State and counters are registered.
- Latency with zero wait states, in cycles: j = 2, beq = 3, R/ori/addiu = 4, sw = 4, lw = 5. Each wait cycle adds 1.
- instru must stay stable from the ir_wr edge until the following FETCH.

## Structure
- Shared package mc_pkg holds:
  - state codes: FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, FAULT=7;
  - opcode constants;
  - alu_op codes;
  - class enum;
  - fault codes.
- One sub-module, mc_wait_timer: wait counter plus timeout compare, sized $clog2(TIMEOUT+1).

## Test plan
- R add (opcode 000000, func 100000), mem_ready held 1: states FETCH, DECODE, EXEC, WB; alu_op=4 in EXEC; reg_wr=1 and reg_dst=1 in WB; retire_cnt goes 0 to 1.
- lw (100011) with mem_ready low for 3 cycles in MEMRD: total 8 cycles; mem_to_reg=1 in WB; ext_op=1.
- beq (000100) run twice, zero=1 then zero=0: pc_wr=1 with pc_src=01 in EXEC only for the zero=1 case; 3 cycles each.
- Illegal opcode 111111: FAULT on the cycle after DECODE; fault_code=01; all strobes stay 0 for 20 cycles; rst_n low returns to FETCH with fault=0.
- TIMEOUT=4, sw (101011) with mem_ready stuck at 0: FAULT with fault_code=10 after 4 wait cycles; repeat with mem_ready=1 on exactly the 4th wait cycle: no fault, retire.
- COUNT_W=4, 16 j (000010) instructions: retire_cnt wraps to 0; each j takes 2 cycles with pc_src=10.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_MEMWR  = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_FUNC = 3'd4;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [2:0] {
    CLS_R     = 3'd0,
    CLS_ORI   = 3'd1,
    CLS_ADDIU = 3'd2,
    CLS_LW    = 3'd3,
    CLS_SW    = 3'd4,
    CLS_BEQ   = 3'd5,
    CLS_J     = 3'd6,
    CLS_ILL   = 3'd7
  } class_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_ILLEGAL = 2'b01,
    FLT_TIMEOUT = 2'b10
  } fault_e;

  // Per-cycle datapath strobe bundle
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       reg_dst;
    logic       r_type;
    logic       reg_wr;
    logic       mem_to_reg;
  } ctrl_t;

  // Map an opcode onto the instruction class it executes as
  function automatic class_e decode_op(input logic [5:0] op);
    class_e cls;
    case (op)
      OP_RTYPE: cls = CLS_R;
      OP_ORI:   cls = CLS_ORI;
      OP_ADDIU: cls = CLS_ADDIU;
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_BEQ:   cls = CLS_BEQ;
      OP_J:     cls = CLS_J;
      default:  cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Consecutive memory wait-cycle counter with timeout detect.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic wait_en,
  input  logic mem_ready,
  output logic timeout_c
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear on access entry, count each cycle the access is stalled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wait_en && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT-th consecutive stalled cycle; a ready on that cycle wins
  assign timeout_c = (TIMEOUT != 0) && wait_en && !mem_ready && (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS subset.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instru,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_wr,
  output logic               pc_wr,
  output logic [1:0]         pc_src,
  output logic               alu_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               ext_op,
  output logic               reg_dst,
  output logic               r_type,
  output logic               reg_wr,
  output logic               mem_to_reg,
  output logic [5:0]         func,
  output logic [2:0]         state,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [COUNT_W-1:0] retire_cnt
);

  state_e               state_q, state_d;
  class_e               class_q, class_d;
  logic                 fault_q, fault_d;
  fault_e               fault_code_q, fault_code_d;
  logic [COUNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic                 retire_c;
  logic                 wait_en_c;
  logic                 wait_clr_c;
  logic                 timeout_c;
  logic [5:0]           opcode_c;
  class_e               dec_class_c;
  ctrl_t                ctrl_c;
  logic                 unused_instr_c;

  assign opcode_c       = instru[31:26];
  assign dec_class_c    = decode_op(opcode_c);
  assign unused_instr_c = ^instru[25:6];

  mc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (wait_clr_c),
    .wait_en   (wait_en_c),
    .mem_ready (mem_ready),
    .timeout_c (timeout_c)
  );

  // State, class, fault and retire registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      class_q      <= CLS_R;
      fault_q      <= 1'b0;
      fault_code_q <= FLT_NONE;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Next-state, retire and fault bookkeeping
  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    retire_c     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_c) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        class_d = dec_class_c;
        case (dec_class_c)
          CLS_J: begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
          CLS_ILL: begin
            state_d      = ST_FAULT;
            fault_code_d = FLT_ILLEGAL;
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (class_q)
          CLS_R, CLS_ORI, CLS_ADDIU: state_d = ST_WB;
          CLS_LW:                    state_d = ST_MEMRD;
          CLS_SW:                    state_d = ST_MEMWR;
          CLS_BEQ: begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end
          default: begin
            state_d      = ST_FAULT;
            fault_code_d = FLT_ILLEGAL;
          end
        endcase
      end
      ST_MEMRD: begin
        if (mem_ready) begin
          state_d = ST_WB;
        end else if (timeout_c) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_TIMEOUT;
        end
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = ST_FETCH;
        end else if (timeout_c) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_TIMEOUT;
        end
      end
      ST_WB: begin
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
    if (state_d == ST_FAULT) begin
      fault_d = 1'b1;
    end
    retire_cnt_d = retire_c ? retire_cnt_q + COUNT_W'(1) : retire_cnt_q;
    wait_en_c    = state_q inside {ST_FETCH, ST_MEMRD, ST_MEMWR};
    wait_clr_c   = (state_d != state_q) && (state_d inside {ST_FETCH, ST_MEMRD, ST_MEMWR});
  end

  // Per-cycle strobes; ALU controls persist from EXEC to the end of the instruction
  always_comb begin
    ctrl_c = '0;
    if (state_q inside {ST_EXEC, ST_MEMRD, ST_MEMWR, ST_WB}) begin
      case (class_q)
        CLS_R: begin
          ctrl_c.alu_op = ALU_FUNC;
          ctrl_c.r_type = 1'b1;
        end
        CLS_ORI: begin
          ctrl_c.alu_op  = ALU_OR;
          ctrl_c.alu_src = 1'b1;
        end
        CLS_ADDIU, CLS_LW, CLS_SW: begin
          ctrl_c.alu_op  = ALU_ADD;
          ctrl_c.ext_op  = 1'b1;
          ctrl_c.alu_src = 1'b1;
        end
        CLS_BEQ: ctrl_c.alu_op = ALU_SUB;
        default: ;
      endcase
    end
    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl_c.ir_wr  = 1'b1;
          ctrl_c.pc_wr  = 1'b1;
          ctrl_c.pc_src = PC_SEQ;
        end
      end
      ST_DECODE: begin
        if (dec_class_c == CLS_J) begin
          ctrl_c.pc_wr  = 1'b1;
          ctrl_c.pc_src = PC_JMP;
        end
      end
      ST_EXEC: begin
        if (class_q == CLS_BEQ) begin
          ctrl_c.pc_wr  = zero;
          ctrl_c.pc_src = PC_BR;
        end
      end
      ST_MEMRD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.iord    = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.mem_we  = 1'b1;
        ctrl_c.iord    = 1'b1;
      end
      ST_WB: begin
        ctrl_c.reg_wr     = 1'b1;
        ctrl_c.reg_dst    = (class_q == CLS_R);
        ctrl_c.mem_to_reg = (class_q == CLS_LW);
      end
      default: ;
    endcase
    if (!rst_n) begin
      ctrl_c = '0;
    end
  end

  assign mem_req    = ctrl_c.mem_req;
  assign mem_we     = ctrl_c.mem_we;
  assign iord       = ctrl_c.iord;
  assign ir_wr      = ctrl_c.ir_wr;
  assign pc_wr      = ctrl_c.pc_wr;
  assign pc_src     = ctrl_c.pc_src;
  assign alu_src    = ctrl_c.alu_src;
  assign alu_op     = ALUOP_W'(ctrl_c.alu_op);
  assign ext_op     = ctrl_c.ext_op;
  assign reg_dst    = ctrl_c.reg_dst;
  assign r_type     = ctrl_c.r_type;
  assign reg_wr     = ctrl_c.reg_wr;
  assign mem_to_reg = ctrl_c.mem_to_reg;
  assign func       = instru[5:0];
  assign state      = state_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [31:0] instru;
  logic        mem_ready;
  logic        zero;

  logic       mem_req, mem_we, iord, ir_wr, pc_wr, alu_src, ext_op, reg_dst, r_type, reg_wr, mem_to_reg, fault;
  logic [1:0] pc_src, fault_code;
  logic [2:0] alu_op, state;
  logic [5:0] func;
  logic [3:0] retire_cnt;

  logic       n_mem_req, n_mem_we, n_iord, n_ir_wr, n_pc_wr, n_alu_src, n_ext_op, n_reg_dst, n_r_type, n_reg_wr, n_mem_to_reg, n_fault;
  logic [1:0] n_pc_src, n_fault_code;
  logic [2:0] n_alu_op, n_state;
  logic [5:0] n_func;
  logic [3:0] n_retire_cnt;

  int tests;
  int fails;
  logic strobe_seen;

  multicycle_control #(.INSTR_W(32), .ALUOP_W(3), .TIMEOUT(4), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instru(instru), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr),
    .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .reg_dst(reg_dst),
    .r_type(r_type), .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .func(func), .state(state),
    .fault(fault), .fault_code(fault_code), .retire_cnt(retire_cnt)
  );

  // Same stimulus, timeout disabled
  multicycle_control #(.INSTR_W(32), .ALUOP_W(3), .TIMEOUT(0), .COUNT_W(4)) dut_nt (
    .clk(clk), .rst_n(rst_n), .instru(instru), .mem_ready(mem_ready), .zero(zero),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .iord(n_iord), .ir_wr(n_ir_wr), .pc_wr(n_pc_wr),
    .pc_src(n_pc_src), .alu_src(n_alu_src), .alu_op(n_alu_op), .ext_op(n_ext_op), .reg_dst(n_reg_dst),
    .r_type(n_r_type), .reg_wr(n_reg_wr), .mem_to_reg(n_mem_to_reg), .func(n_func), .state(n_state),
    .fault(n_fault), .fault_code(n_fault_code), .retire_cnt(n_retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; instru = 32'h0000_0020;
    cyc(); cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir_wr", 32'(ir_wr), 32'd0);

    // R add: FETCH strobes appear as soon as reset is released
    rst_n = 1'b1; #1;
    chk("fetch_mem_req", 32'(mem_req), 32'd1);
    chk("fetch_iord", 32'(iord), 32'd0);
    chk("fetch_ir_wr", 32'(ir_wr), 32'd1);
    chk("fetch_pc_wr", 32'(pc_wr), 32'd1);
    chk("fetch_pc_src", 32'(pc_src), 32'd0);
    chk("func", 32'(func), 32'h20);
    cyc();
    chk("r_dec_state", 32'(state), 32'd1);
    chk("r_dec_mem_req", 32'(mem_req), 32'd0);
    cyc();
    chk("r_exec_state", 32'(state), 32'd2);
    chk("r_exec_alu_op", 32'(alu_op), 32'd4);
    chk("r_exec_alu_src", 32'(alu_src), 32'd0);
    chk("r_exec_r_type", 32'(r_type), 32'd1);
    chk("r_exec_reg_wr", 32'(reg_wr), 32'd0);
    cyc();
    chk("r_wb_state", 32'(state), 32'd5);
    chk("r_wb_reg_wr", 32'(reg_wr), 32'd1);
    chk("r_wb_reg_dst", 32'(reg_dst), 32'd1);
    chk("r_wb_mem_to_reg", 32'(mem_to_reg), 32'd0);
    chk("r_wb_alu_op", 32'(alu_op), 32'd4);
    chk("r_wb_retire", 32'(retire_cnt), 32'd0);
    cyc();
    chk("r_done_state", 32'(state), 32'd0);
    chk("r_done_retire", 32'(retire_cnt), 32'd1);

    // lw with three wait cycles in MEMRD: 8 cycles total
    instru = 32'h8C00_0000;
    cyc();
    chk("lw_dec_state", 32'(state), 32'd1);
    cyc();
    chk("lw_exec_alu_op", 32'(alu_op), 32'd0);
    chk("lw_exec_ext_op", 32'(ext_op), 32'd1);
    chk("lw_exec_alu_src", 32'(alu_src), 32'd1);
    mem_ready = 1'b0;
    cyc();
    chk("lw_memrd_state", 32'(state), 32'd3);
    chk("lw_memrd_req", 32'(mem_req), 32'd1);
    chk("lw_memrd_iord", 32'(iord), 32'd1);
    chk("lw_memrd_we", 32'(mem_we), 32'd0);
    chk("lw_memrd_ext_op", 32'(ext_op), 32'd1);
    cyc(); cyc(); cyc();
    chk("lw_wait_state", 32'(state), 32'd3);
    mem_ready = 1'b1;
    cyc();
    chk("lw_wb_state", 32'(state), 32'd5);
    chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
    chk("lw_wb_reg_wr", 32'(reg_wr), 32'd1);
    chk("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
    chk("lw_wb_ext_op", 32'(ext_op), 32'd1);
    cyc();
    chk("lw_done_state", 32'(state), 32'd0);
    chk("lw_done_retire", 32'(retire_cnt), 32'd2);

    // beq taken then not taken
    instru = 32'h1000_0000; zero = 1'b1;
    cyc(); cyc();
    chk("beq1_state", 32'(state), 32'd2);
    chk("beq1_alu_op", 32'(alu_op), 32'd1);
    chk("beq1_alu_src", 32'(alu_src), 32'd0);
    chk("beq1_pc_wr", 32'(pc_wr), 32'd1);
    chk("beq1_pc_src", 32'(pc_src), 32'd1);
    cyc();
    chk("beq1_done_state", 32'(state), 32'd0);
    chk("beq1_retire", 32'(retire_cnt), 32'd3);
    zero = 1'b0;
    cyc(); cyc();
    chk("beq0_state", 32'(state), 32'd2);
    chk("beq0_pc_wr", 32'(pc_wr), 32'd0);
    cyc();
    chk("beq0_done_state", 32'(state), 32'd0);
    chk("beq0_retire", 32'(retire_cnt), 32'd4);

    // sw with memory stuck: timeout after 4 wait cycles
    instru = 32'hAC00_0000;
    cyc(); cyc();
    chk("sw_exec_ext_op", 32'(ext_op), 32'd1);
    mem_ready = 1'b0;
    cyc();
    chk("sw_memwr_state", 32'(state), 32'd4);
    chk("sw_memwr_req", 32'(mem_req), 32'd1);
    chk("sw_memwr_we", 32'(mem_we), 32'd1);
    chk("sw_memwr_iord", 32'(iord), 32'd1);
    cyc(); cyc(); cyc();
    chk("sw_wait4_state", 32'(state), 32'd4);
    cyc();
    chk("to_state", 32'(state), 32'd7);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_code", 32'(fault_code), 32'd2);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    chk("to_retire", 32'(retire_cnt), 32'd4);
    chk("nt_state", 32'(n_state), 32'd4);
    repeat (6) cyc();
    chk("nt_state_late", 32'(n_state), 32'd4);
    chk("nt_fault_late", 32'(n_fault), 32'd0);

    // sw with ready on exactly the 4th wait cycle: completes
    rst_n = 1'b0; mem_ready = 1'b1;
    cyc();
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_fault", 32'(fault), 32'd0);
    chk("rst2_retire", 32'(retire_cnt), 32'd0);
    rst_n = 1'b1;
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("sw4_state", 32'(state), 32'd4);
    mem_ready = 1'b1; #1;
    chk("sw4_we", 32'(mem_we), 32'd1);
    cyc();
    chk("sw4_done_state", 32'(state), 32'd0);
    chk("sw4_fault", 32'(fault), 32'd0);
    chk("sw4_retire", 32'(retire_cnt), 32'd1);

    // Illegal opcode: sticky fault with all strobes quiet
    instru = 32'hFC00_0000;
    cyc();
    chk("ill_dec_state", 32'(state), 32'd1);
    cyc();
    chk("ill_state", 32'(state), 32'd7);
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_code", 32'(fault_code), 32'd1);
    strobe_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      #1;
      strobe_seen = strobe_seen | mem_req | mem_we | iord | ir_wr | pc_wr | reg_wr | alu_src | ext_op | r_type | (|alu_op);
      cyc();
    end
    chk("ill_strobes", 32'(strobe_seen), 32'd0);
    chk("ill_state_held", 32'(state), 32'd7);
    chk("ill_retire", 32'(retire_cnt), 32'd1);
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    cyc();
    chk("rst3_state", 32'(state), 32'd0);
    chk("rst3_fault", 32'(fault), 32'd0);
    chk("rst3_code", 32'(fault_code), 32'd0);
    chk("rst3_mem_req", 32'(mem_req), 32'd0);

    // 16 jumps wrap a 4-bit retire counter
    instru = 32'h0800_0000;
    rst_n = 1'b1; #1;
    chk("j_func", 32'(func), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("j_dec_state", 32'(state), 32'd1);
      chk("j_pc_wr", 32'(pc_wr), 32'd1);
      chk("j_pc_src", 32'(pc_src), 32'd2);
      cyc();
      chk("j_fetch_state", 32'(state), 32'd0);
      chk("j_retire", 32'(retire_cnt), 32'((i + 1) % 16));
    end

    // Reset in WB kills the register write
    instru = 32'h0000_0020;
    cyc(); cyc(); cyc();
    chk("abort_wb_state", 32'(state), 32'd5);
    chk("abort_wb_reg_wr", 32'(reg_wr), 32'd1);
    rst_n = 1'b0; #1;
    chk("abort_reg_wr", 32'(reg_wr), 32'd0);
    cyc();
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_retire", 32'(retire_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
